// File: rtl/prog_seq_pkg.sv
// Shared constants for the programmable sequence counter: mode encodings,
// the mode type and the default table geometry/contents.
package prog_seq_pkg;

  typedef logic [1:0] seq_mode_t;

  localparam seq_mode_t MODE_WRAP     = 2'b00;
  localparam seq_mode_t MODE_ONESHOT  = 2'b01;
  localparam seq_mode_t MODE_PINGPONG = 2'b10;
  localparam seq_mode_t MODE_RSVD     = 2'b11;  // behaves as wrap

  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 8;

  // Entry 0 sits in the least significant nibble.
  localparam logic [WIDTH_DEF*DEPTH_DEF-1:0] DEFAULT_SEQ_DEF =
    {4'd15, 4'd12, 4'd11, 4'd9, 4'd5, 4'd3, 4'd2, 4'd1};

endpackage

// File: rtl/seq_table.sv
// DEPTH x WIDTH register file holding the count sequence. Reset reloads the
// default contents; one synchronous write port, one combinational read port.
module seq_table #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter logic [WIDTH*DEPTH-1:0] INIT = '0,
  localparam int IDXW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDXW-1:0]  rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Table storage: reset to the default sequence, written on wr_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= INIT[i*WIDTH +: WIDTH];
      end
    end else if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read port returns pre-write contents; the top handles write-through.
  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/prog_seq_counter.sv
// Table-driven sequence counter. Steps an index through a writable table in
// wrap, one-shot or ping-pong mode and registers the selected entry onto q.
// tc pulses on the step that lands on an end of the sequence (and on the step
// that finishes a one-shot run). The table read is write-through so q always
// equals the post-write contents of the entry being loaded.
module prog_seq_counter
  import prog_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter logic [WIDTH*DEPTH-1:0] DEFAULT_SEQ = DEFAULT_SEQ_DEF,
  localparam int IDXW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [IDXW-1:0]  last_idx,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] q,
  output logic [IDXW-1:0]  idx,
  output logic             tc,
  output logic             done
);

  localparam logic [IDXW-1:0] ZERO_IDX = '0;
  localparam logic [IDXW-1:0] ONE_IDX  = IDXW'(1);
  localparam logic [IDXW-1:0] LAST_MAX = IDXW'(DEPTH - 1);

  seq_mode_t        mode_s;
  logic [IDXW-1:0]  li;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             pp_up_q, pp_up_d;
  logic             go_up;
  logic [WIDTH-1:0] rd_data;

  assign mode_s = seq_mode_t'(mode);

  // Lengths beyond the table are clamped to the final entry.
  assign li = (int'(last_idx) > DEPTH - 1) ? LAST_MAX : last_idx;

  seq_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .INIT  (DEFAULT_SEQ)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_d),
    .rd_data (rd_data)
  );

  // Next index, direction, done and terminal-count decisions.
  always_comb begin
    idx_d   = idx_q;
    done_d  = done_q;
    pp_up_d = pp_up_q;
    tc_d    = 1'b0;
    go_up   = 1'b0;
    if (restart) begin
      idx_d   = ZERO_IDX;
      done_d  = 1'b0;
      pp_up_d = 1'b1;
    end else if (en && !done_q) begin
      case (mode_s)
        MODE_ONESHOT: begin
          if (dir) begin
            if (idx_q >= li) begin
              done_d = 1'b1;
              tc_d   = 1'b1;
            end else begin
              idx_d = idx_q + ONE_IDX;
              tc_d  = (idx_d == li);
            end
          end else begin
            if (idx_q == ZERO_IDX) begin
              done_d = 1'b1;
              tc_d   = 1'b1;
            end else begin
              idx_d = idx_q - ONE_IDX;
              tc_d  = (idx_d == ZERO_IDX);
            end
          end
        end
        MODE_PINGPONG: begin
          if (li == ZERO_IDX || idx_q > li) begin
            // Single-entry sequence holds; an index beyond the end restarts.
            idx_d   = ZERO_IDX;
            pp_up_d = 1'b1;
            tc_d    = 1'b1;
          end else begin
            // Turn around at either end even if pp_up is stale from another mode.
            go_up   = pp_up_q ? (idx_q != li) : (idx_q == ZERO_IDX);
            idx_d   = go_up ? (idx_q + ONE_IDX) : (idx_q - ONE_IDX);
            pp_up_d = go_up;
            if (idx_d == li)       pp_up_d = 1'b0;
            if (idx_d == ZERO_IDX) pp_up_d = 1'b1;
            tc_d    = (idx_d == li) || (idx_d == ZERO_IDX);
          end
        end
        default: begin
          if (dir) begin
            idx_d = (idx_q >= li) ? ZERO_IDX : (idx_q + ONE_IDX);
            tc_d  = (idx_d == li);
          end else begin
            idx_d = (idx_q == ZERO_IDX || idx_q > li) ? li : (idx_q - ONE_IDX);
            tc_d  = (idx_d == ZERO_IDX);
          end
        end
      endcase
    end
  end

  // q follows the entry being loaded, taking wr_data when that entry is written now.
  always_comb begin
    q_d = rd_data;
    if (wr_en && (wr_addr == idx_d)) q_d = wr_data;
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= ZERO_IDX;
      q_q     <= DEFAULT_SEQ[WIDTH-1:0];
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      pp_up_q <= 1'b1;
    end else begin
      idx_q   <= idx_d;
      q_q     <= q_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      pp_up_q <= pp_up_d;
    end
  end

  assign q    = q_q;
  assign idx  = idx_q;
  assign tc   = tc_q;
  assign done = done_q;

endmodule
